tristate_bus_arbiter: RTL and testbench

Parametrised shared-bus driver for the single-cycle CPU datapath. It arbitrates NUM_SRC requesters onto one WIDTH-bit tristate bus using round-robin arbitration. Each grant is capped at a burst limit. A mandatory one-cycle all-Z turnaround separates different owners. The bus is driven only by the granted source and is high-impedance otherwise.

---
 rtl/tristate_bus_arbiter.sv | 147 ++++++++++++++
 tb/tb_tristate_bus_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter driving NUM_SRC sources onto one shared WIDTH-bit tristate bus.
// Latency: request to grant in 1 cycle. A grant is capped at MAX_BURST cycles while others wait. One all-Z turnaround cycle separates owners.
// Backpressure: requesters hold req level until served. Optional macro CONTENTION_CHK_EN adds a sticky ext_en-vs-drive contention flag.
module tristate_bus_arbiter #(
  parameter int WIDTH     = 32,
  parameter int NUM_SRC   = 4,
  parameter int SEL_W     = 2,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_SRC-1:0]       req,
  input  logic [NUM_SRC*WIDTH-1:0] data_in,
  input  logic                     ext_en,
  output logic [WIDTH-1:0]         bus_out,
  output logic [NUM_SRC-1:0]       gnt,
  output logic [SEL_W-1:0]         owner,
  output logic                     bus_valid,
  output logic                     err_contention
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0]   owner_q, owner_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [SEL_W-1:0]   win;
  logic [SEL_W-1:0]   scan_idx;
  logic               any_req;
  logic               others_req;
  logic               stay;
  logic               bus_en;

  // Round-robin winner: first set request bit scanning upward from ptr+1 with wrap.
  // The scan runs from the farthest slot to the nearest so the nearest hit is written last.
  always_comb begin
    win      = '0;
    scan_idx = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      scan_idx = SEL_W'((int'(ptr_q) + k) % NUM_SRC);
      if (req[scan_idx]) begin
        win = scan_idx;
      end
    end
  end

  assign any_req    = |req;
  assign others_req = |(req & ~(NUM_SRC'(1) << owner_q));
  // Keep the bus while still requesting, unless the burst cap is hit and someone else is waiting.
  assign stay       = req[owner_q] && ((cnt_q < CW'(MAX_BURST)) || !others_req);

  // State and registered outputs; reset releases the bus immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= SEL_W'(NUM_SRC - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: arbitrate from IDLE/TURN, enforce burst cap and turnaround from DRIVE.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, TURN: begin
        if (any_req) begin
          state_d = DRIVE;
          gnt_d   = NUM_SRC'(1) << win;
          owner_d = win;
          cnt_d   = CW'(1);
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      DRIVE: begin
        if (stay) begin
          if (cnt_q < CW'(MAX_BURST)) begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          // Leaving: the next owner search starts just after the one that released.
          state_d = TURN;
          gnt_d   = '0;
          ptr_d   = owner_q;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Output decode: drive enable comes only from registered state.
  always_comb begin
    bus_en = (state_q == DRIVE);
  end

  assign bus_valid = bus_en;
  assign gnt       = gnt_q;
  assign owner     = owner_q;
  // Data path is combinational from the owner's slice.
  assign bus_out   = bus_en ? data_in[int'(owner_q)*WIDTH +: WIDTH] : {WIDTH{1'bz}};

`ifdef CONTENTION_CHK_EN
  logic err_q;

  // Sticky flag: an external driver was enabled while we owned the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (ext_en && (state_q == DRIVE)) begin
      err_q <= 1'b1;
    end
  end

  assign err_contention = err_q;
`else
  logic ext_en_unused;

  assign ext_en_unused  = ext_en;
  assign err_contention = 1'b0;
`endif

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Self-checking bench for tristate_bus_arbiter: directed scenarios plus randomized traffic against a cycle model.
// The bus net is pulled high, so a released (all-Z) bus reads as all ones.
// Honours CONTENTION_CHK_EN the same way the design does.
module tb_tristate_bus_arbiter;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int SW = 2;
  localparam int MB = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req;
  logic [N*W-1:0]   data_in;
  logic             ext_en;
  tri1  [W-1:0]     bus_out;
  logic [N-1:0]     gnt;
  logic [SW-1:0]    owner;
  logic             bus_valid;
  logic             err_contention;

  int errors = 0;
  int checks = 0;

  // Model state: is someone driving, who, how long, and where the rotation resumes.
  bit           m_drv;
  int           m_own;
  int           m_burst;
  int           m_ptr;
  bit           m_err;
  logic [N-1:0] prev_gnt;

  localparam logic [W-1:0] RELEASED = {W{1'b1}};

  tristate_bus_arbiter #(.WIDTH(W), .NUM_SRC(N), .SEL_W(SW), .MAX_BURST(MB)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req            (req),
    .data_in        (data_in),
    .ext_en         (ext_en),
    .bus_out        (bus_out),
    .gnt            (gnt),
    .owner          (owner),
    .bus_valid      (bus_valid),
    .err_contention (err_contention)
  );

  always #5 clk = ~clk;

  function automatic int pick(logic [N-1:0] r, int p);
    for (int k = 1; k <= N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_drv    = 0;
    m_own    = 0;
    m_burst  = 0;
    m_ptr    = N - 1;
    m_err    = 0;
    prev_gnt = '0;
  endtask

  task automatic model_edge();
    bit other;
`ifdef CONTENTION_CHK_EN
    if (ext_en && m_drv) m_err = 1;
`endif
    if (m_drv) begin
      other = (req & ~(N'(1) << m_own)) != '0;
      if (req[m_own] && (m_burst < MB || !other)) begin
        if (m_burst < MB) m_burst++;
      end else begin
        m_drv = 0;
        m_ptr = m_own;
      end
    end else if (req != '0) begin
      m_own   = pick(req, m_ptr);
      m_drv   = 1;
      m_burst = 1;
    end
  endtask

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    logic [N-1:0] eg;
    logic [W-1:0] eb;
    eg = m_drv ? (N'(1) << m_own) : '0;
    eb = m_drv ? data_in[m_own*W +: W] : RELEASED;
    check({tag, ".gnt"}, 64'(gnt), 64'(eg));
    check({tag, ".owner"}, 64'(owner), 64'(m_own));
    check({tag, ".valid"}, 64'(bus_valid), 64'(m_drv));
    check({tag, ".bus"}, 64'(bus_out), 64'(eb));
    check({tag, ".err"}, 64'(err_contention), 64'(m_err));
    check({tag, ".onehot0"}, 64'($onehot0(gnt)), 64'(1));
    if (prev_gnt != '0 && gnt != '0) check({tag, ".adjacent"}, 64'(gnt), 64'(prev_gnt));
    prev_gnt = gnt;
  endtask

  task automatic cyc(string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    logic [N-1:0] exp_g;
    rst_n  = 1'b1;
    req    = 4'b1111;
    ext_en = 1'b0;
    for (int i = 0; i < N; i++) data_in[i*W +: W] = $urandom;
    #1 rst_n = 1'b0;
    model_reset();

    // Reset with all requesting: nothing granted, bus released.
    @(negedge clk);
    check_all("rst");
    check("rst.gnt_const", 64'(gnt), 64'(0));
    check("rst.bus_const", 64'(bus_out), 64'(RELEASED));
    rst_n = 1'b1;

    // First grant one cycle after release goes to source 0, then full round-robin with caps.
    cyc("rr");
    check("rr.first_gnt", 64'(gnt), 64'(4'b0001));
    check("rr.first_bus", 64'(bus_out), 64'(data_in[W-1:0]));
    for (int c = 1; c < 20; c++) begin
      cyc("rr");
      exp_g = ((c % 5) < 4) ? (N'(1) << ((c / 5) % 4)) : '0;
      check("rr.seq", 64'(gnt), 64'(exp_g));
    end

    // Lone requester keeps the bus with no turnaround.
    req = '0;
    cyc("idle");
    cyc("idle");
    req = 4'b0010;
    for (int c = 0; c < 20; c++) begin
      cyc("solo");
      check("solo.gnt", 64'(gnt), 64'(4'b0010));
    end

    // Release: drives through the cycle where req falls, then one Z cycle, then idle.
    req = '0;
    cyc("rel");
    cyc("rel");
    data_in[2*W +: W] = 32'hA5A5_0001;
    req = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      cyc("drop");
      check("drop.bus", 64'(bus_out), 64'(32'hA5A5_0001));
      check("drop.valid", 64'(bus_valid), 64'(1));
    end
    req = '0;
    cyc("turn");
    check("turn.bus", 64'(bus_out), 64'(RELEASED));
    check("turn.valid", 64'(bus_valid), 64'(0));
    check("turn.gnt", 64'(gnt), 64'(0));
    cyc("after_turn");
    check("after_turn.gnt", 64'(gnt), 64'(0));

    // Asynchronous reset between clock edges releases the bus at once.
    req = 4'b1000;
    cyc("pre_arst");
    check("pre_arst.gnt", 64'(gnt), 64'(4'b1000));
    #2 rst_n = 1'b0;
    #1;
    check("arst.bus", 64'(bus_out), 64'(RELEASED));
    check("arst.gnt", 64'(gnt), 64'(0));
    check("arst.valid", 64'(bus_valid), 64'(0));
    check("arst.owner", 64'(owner), 64'(0));
    model_reset();
    @(negedge clk);
    check_all("arst_hold");
    rst_n = 1'b1;
    req   = 4'b1111;
    cyc("post_arst");
    check("post_arst.gnt", 64'(gnt), 64'(4'b0001));

    // Contention pulse during a drive cycle.
    ext_en = 1'b1;
    cyc("cont");
    ext_en = 1'b0;
`ifdef CONTENTION_CHK_EN
    check("cont.set", 64'(err_contention), 64'(1));
`else
    check("cont.tied", 64'(err_contention), 64'(0));
`endif
    for (int c = 0; c < 3; c++) cyc("cont_hold");
    rst_n = 1'b0;
    #1;
    model_reset();
    check("cont.clear", 64'(err_contention), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom);
      for (int i = 0; i < N; i++) data_in[i*W +: W] = $urandom;
      ext_en = ($urandom_range(0, 29) == 0);
      cyc("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
